cache_req_dispatch: RTL and testbench
=====================================

CACHE_REQ_DISPATCH -- requirements
Module: cache_req_dispatch

Interface
REQ-001 SHALL have parameter DATA_BIT_SIZE, default 8, meaning request word width: bit [DATA_BIT_SIZE-1] is is_write, bits [DATA_BIT_SIZE-2:0] are address.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, meaning maximum reads issued without a response (range 1..15).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic on rising edge.
REQ-004 SHALL have port reset_n, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port fifo_empty, input, 1, meaning the upstream request FIFO is empty.
REQ-006 SHALL have port fifo_read_data, input, DATA_BIT_SIZE, meaning the FIFO head word, valid combinationally while fifo_empty=0.
REQ-007 SHALL have port fifo_read_en, output, 1, meaning pop FIFO head this cycle.
REQ-008 SHALL have ports cmd_valid (output, 1), cmd_ready (input, 1), cmd_write (output, 1), cmd_addr (output, DATA_BIT_SIZE-1), meaning the DRAM command handshake.
REQ-009 SHALL have port rsp_valid, input, 1, meaning one read response returned this cycle.
REQ-010 SHALL have ports flush (input, 1), flush_done (output, 1), outstanding (output, 4), err_underflow (output, 1).

Function
REQ-011 SHALL hold one request in a holding register; cmd_valid = holding register valid; cmd_write/cmd_addr driven from it.
REQ-012 SHALL assert fifo_read_en iff fifo_empty=0, state IDLE or HOLD, holding register empty or firing (cmd_valid&&cmd_ready) this cycle, and (head is_write=1 or outstanding < MAX_OUTSTANDING).
REQ-013 SHALL load fifo_read_data into the holding register at the edge where fifo_read_en=1; back-to-back pop and fire gives one command per cycle.
REQ-014 SHALL keep cmd_valid, cmd_write, cmd_addr stable while cmd_valid=1 and cmd_ready=0.
REQ-015 SHALL issue strictly in FIFO order; a credit-blocked read at the head blocks following writes.
REQ-016 SHALL increment outstanding when a read is popped, decrement on rsp_valid, net unchanged when both occur in the same cycle.
REQ-017 SHALL, on rsp_valid with outstanding=0 and no same-cycle read pop, leave outstanding at 0 and set err_underflow sticky until reset.
REQ-018 SHALL implement FSM IDLE (holding empty), HOLD (holding valid), FLUSH_WAIT, FLUSH_DONE.
REQ-019 SHALL transition IDLE->HOLD on pop, HOLD->IDLE on fire without pop, HOLD->HOLD on fire with pop or on stall.
REQ-020 SHALL on flush=1 in IDLE or HOLD go to FLUSH_WAIT; no pops in FLUSH_WAIT; a held request still issues.
REQ-021 SHALL go FLUSH_WAIT->FLUSH_DONE when holding empty and outstanding=0, assert flush_done for exactly one cycle in FLUSH_DONE, then return to IDLE.
REQ-022 SHALL ignore flush while in FLUSH_WAIT or FLUSH_DONE.

Reset
REQ-023 SHALL on reset_n=0 asynchronously force state IDLE, holding register empty and cleared, cmd_valid=0, cmd_write=0, cmd_addr=0, fifo_read_en=0, outstanding=0, flush_done=0, err_underflow=0.
REQ-024 SHALL discard any held or outstanding request on reset mid-operation; no command issued in the first cycle after release.

Configuration
REQ-025 SHALL, with macro CACHE_REQ_DISPATCH_STAT_EN defined, add outputs stat_reads and stat_writes (16 bits each) counting fired read/write commands, wrapping 0xFFFF->0, reset to 0.
REQ-026 SHALL, without CACHE_REQ_DISPATCH_STAT_EN, omit those ports and counters entirely.

Structure
REQ-027 SHALL take the request-word field positions, FSM state enum typedef, and outstanding counter width constant from shared package dram_cache_pkg.
REQ-028 SHALL be a single module with no sub-module; the request FIFO is instantiated by the parent.

Verification
REQ-029 SHALL cover: FIFO holds W@0x12, R@0x34, cmd_ready=1 -> pops on consecutive cycles, commands fire in order on consecutive cycles, outstanding=1.
REQ-030 SHALL cover: 5 reads, MAX_OUTSTANDING=4, no rsp -> exactly 4 fire, fifo_read_en low with fifo_empty=0; one rsp_valid -> 5th popped next cycle.
REQ-031 SHALL cover: cmd_ready=0 for 3 cycles with R@0x05 held -> cmd_valid=1, cmd_addr=0x05 stable, no pop; fires on cmd_ready=1.
REQ-032 SHALL cover: rsp_valid with outstanding=0 -> err_underflow=1 and outstanding stays 0; same cycle as a read pop -> outstanding unchanged, no error.
REQ-033 SHALL cover: flush with 2 reads outstanding and FIFO non-empty -> no pops, flush_done one-cycle pulse the cycle after 2nd rsp_valid, then pops resume.
REQ-034 SHALL cover: reset_n low mid-HOLD with outstanding=3 -> all outputs zero immediately, outstanding=0 after release.

Source files
------------

// File: rtl/dram_cache_pkg.sv
//------------------------------------------------------------------------------
// Package  : dram_cache_pkg
// Purpose  : Shared request-word layout, dispatch FSM states, counter width.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package dram_cache_pkg;

  localparam int unsigned c_outst_w  = 4;
  localparam int unsigned c_addr_lsb = 0;

  // is_write flag lives in the MSB of the request word.
  function automatic int unsigned req_write_bit(input int unsigned data_bits);
    return data_bits - 1;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_HOLD       = 2'd1,
    ST_FLUSH_WAIT = 2'd2,
    ST_FLUSH_DONE = 2'd3
  } disp_state_t;

endpackage

`default_nettype wire

// File: rtl/cache_req_dispatch.sv
//------------------------------------------------------------------------------
// Module   : cache_req_dispatch
// Purpose  : Pops FIFO requests into a holding register and issues DRAM
//            commands with read-credit limiting and flush drain.
//            Optional CACHE_REQ_DISPATCH_STAT_EN adds fired read/write counters.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cache_req_dispatch
  import dram_cache_pkg::*;
#(
  parameter int unsigned DATA_BIT_SIZE   = 8,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     fifo_empty,
  input  logic [DATA_BIT_SIZE-1:0] fifo_read_data,
  output logic                     fifo_read_en,
  output logic                     cmd_valid,
  input  logic                     cmd_ready,
  output logic                     cmd_write,
  output logic [DATA_BIT_SIZE-2:0] cmd_addr,
  input  logic                     rsp_valid,
  input  logic                     flush,
  output logic                     flush_done,
  output logic [c_outst_w-1:0]     outstanding,
  output logic                     err_underflow
`ifdef CACHE_REQ_DISPATCH_STAT_EN
  ,
  output logic [15:0]              stat_reads,
  output logic [15:0]              stat_writes
`endif
);

  localparam int unsigned          c_wr_bit  = req_write_bit(DATA_BIT_SIZE);
  localparam logic [c_outst_w-1:0] c_max_out = c_outst_w'(MAX_OUTSTANDING);

  disp_state_t                r_state;
  disp_state_t                w_state_nxt;
  logic                       r_hold_valid;
  logic                       r_hold_write;
  logic [DATA_BIT_SIZE-2:0]   r_hold_addr;
  logic [c_outst_w-1:0]       r_outstanding;
  logic [c_outst_w-1:0]       w_outst_nxt;
  logic                       r_err;
  logic                       w_fire;
  logic                       w_head_write;
  logic                       w_pop;
  logic                       w_rd_pop;
  logic                       w_underflow;

  always_comb begin
    w_fire       = r_hold_valid & cmd_ready;
    w_head_write = fifo_read_data[c_wr_bit];
    // Reset gates the pop so the FIFO is untouched while reset_n is low.
    w_pop        = reset_n & ~fifo_empty
                 & ((r_state == ST_IDLE) | (r_state == ST_HOLD))
                 & (~r_hold_valid | w_fire)
                 & (w_head_write | (r_outstanding < c_max_out));
    w_rd_pop     = w_pop & ~w_head_write;
    w_underflow  = rsp_valid & ~w_rd_pop & (r_outstanding == '0);
    w_outst_nxt  = r_outstanding;
    if (w_rd_pop && !rsp_valid) begin
      w_outst_nxt = r_outstanding + c_outst_w'(1);
    end else if (rsp_valid && !w_rd_pop && (r_outstanding != '0)) begin
      w_outst_nxt = r_outstanding - c_outst_w'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (flush)      w_state_nxt = ST_FLUSH_WAIT;
        else if (w_pop) w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (flush)                w_state_nxt = ST_FLUSH_WAIT;
        else if (w_fire && !w_pop) w_state_nxt = ST_IDLE;
      end
      ST_FLUSH_WAIT: begin
        // Look at next-cycle occupancy so the done pulse follows the last rsp.
        if ((!r_hold_valid || w_fire) && (w_outst_nxt == '0))
          w_state_nxt = ST_FLUSH_DONE;
      end
      ST_FLUSH_DONE: w_state_nxt = ST_IDLE;
      default:       w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_hold_valid  <= 1'b0;
      r_hold_write  <= 1'b0;
      r_hold_addr   <= '0;
      r_outstanding <= '0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_outstanding <= w_outst_nxt;
      if (w_underflow) r_err <= 1'b1;
      if (w_pop) begin
        r_hold_valid <= 1'b1;
        r_hold_write <= w_head_write;
        r_hold_addr  <= fifo_read_data[c_wr_bit-1:c_addr_lsb];
      end else if (w_fire) begin
        r_hold_valid <= 1'b0;
      end
    end
  end

  assign fifo_read_en  = w_pop;
  assign cmd_valid     = r_hold_valid;
  assign cmd_write     = r_hold_write;
  assign cmd_addr      = r_hold_addr;
  assign outstanding   = r_outstanding;
  assign err_underflow = r_err;
  assign flush_done    = (r_state == ST_FLUSH_DONE);

`ifdef CACHE_REQ_DISPATCH_STAT_EN
  logic [15:0] r_stat_reads;
  logic [15:0] r_stat_writes;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stat_reads  <= '0;
      r_stat_writes <= '0;
    end else if (w_fire) begin
      if (r_hold_write) r_stat_writes <= r_stat_writes + 16'd1;
      else              r_stat_reads  <= r_stat_reads + 16'd1;
    end
  end

  assign stat_reads  = r_stat_reads;
  assign stat_writes = r_stat_writes;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cache_req_dispatch.sv
//------------------------------------------------------------------------------
// Module   : tb_cache_req_dispatch
// Purpose  : Directed vector bench for cache_req_dispatch.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cache_req_dispatch;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       fifo_empty;
  logic [7:0] fifo_read_data;
  logic       fifo_read_en;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [6:0] cmd_addr;
  logic       rsp_valid;
  logic       flush;
  logic       flush_done;
  logic [3:0] outstanding;
  logic       err_underflow;
`ifdef CACHE_REQ_DISPATCH_STAT_EN
  logic [15:0] stat_reads;
  logic [15:0] stat_writes;
`endif

  cache_req_dispatch #(.DATA_BIT_SIZE(8), .MAX_OUTSTANDING(4)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .fifo_empty     (fifo_empty),
    .fifo_read_data (fifo_read_data),
    .fifo_read_en   (fifo_read_en),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_addr       (cmd_addr),
    .rsp_valid      (rsp_valid),
    .flush          (flush),
    .flush_done     (flush_done),
    .outstanding    (outstanding),
    .err_underflow  (err_underflow)
`ifdef CACHE_REQ_DISPATCH_STAT_EN
    ,
    .stat_reads     (stat_reads),
    .stat_writes    (stat_writes)
`endif
  );

  always #5 clk = ~clk;

  // exp = {ren, cmd_valid, cmd_write, cmd_addr[6:0], outstanding[3:0], flush_done, err}
  typedef struct {
    logic        rst_n;
    logic        empty;
    logic [7:0]  data;
    logic        rdy;
    logic        rsp;
    logic        fl;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input int rst_n, input int empty, input int data,
                              input int rdy, input int rsp, input int fl,
                              input int ren, input int cv, input int cw,
                              input int ca, input int outst, input int fd,
                              input int err);
    vec_t v;
    v.rst_n = 1'(rst_n);
    v.empty = 1'(empty);
    v.data  = 8'(data);
    v.rdy   = 1'(rdy);
    v.rsp   = 1'(rsp);
    v.fl    = 1'(fl);
    v.exp   = {1'(ren), 1'(cv), 1'(cw), 7'(ca), 4'(outst), 1'(fd), 1'(err)};
    return v;
  endfunction

  function automatic logic [15:0] actual();
    return {fifo_read_en, cmd_valid, cmd_write, cmd_addr, outstanding,
            flush_done, err_underflow};
  endfunction

  task automatic check(input string name, input logic [15:0] got,
                       input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;

    // reset, then W@0x12 / R@0x34 back to back
    vecs.push_back(mk(0,0,'h92,1,0,0, 0,0,0,'h00,0,0,0));
    vecs.push_back(mk(1,0,'h92,1,0,0, 1,0,0,'h00,0,0,0));
    vecs.push_back(mk(1,0,'h34,1,0,0, 1,1,1,'h12,0,0,0));
    vecs.push_back(mk(1,1,'h00,1,0,0, 0,1,0,'h34,1,0,0));
    vecs.push_back(mk(1,1,'h00,1,1,0, 0,0,0,'h34,1,0,0));
    vecs.push_back(mk(1,1,'h00,1,0,0, 0,0,0,'h34,0,0,0));
    // five reads against four credits
    vecs.push_back(mk(1,0,'h01,1,0,0, 1,0,0,'h34,0,0,0));
    vecs.push_back(mk(1,0,'h02,1,0,0, 1,1,0,'h01,1,0,0));
    vecs.push_back(mk(1,0,'h03,1,0,0, 1,1,0,'h02,2,0,0));
    vecs.push_back(mk(1,0,'h04,1,0,0, 1,1,0,'h03,3,0,0));
    vecs.push_back(mk(1,0,'h05,1,0,0, 0,1,0,'h04,4,0,0));
    vecs.push_back(mk(1,0,'h05,1,0,0, 0,0,0,'h04,4,0,0));
    vecs.push_back(mk(1,0,'h05,1,1,0, 0,0,0,'h04,4,0,0));
    vecs.push_back(mk(1,0,'h05,1,0,0, 1,0,0,'h04,3,0,0));
    // R@0x05 stalled three cycles, write waiting behind it
    vecs.push_back(mk(1,0,'h86,0,0,0, 0,1,0,'h05,4,0,0));
    vecs.push_back(mk(1,0,'h86,0,0,0, 0,1,0,'h05,4,0,0));
    vecs.push_back(mk(1,0,'h86,0,0,0, 0,1,0,'h05,4,0,0));
    vecs.push_back(mk(1,0,'h86,1,0,0, 1,1,0,'h05,4,0,0));
    vecs.push_back(mk(1,1,'h00,1,0,0, 0,1,1,'h06,4,0,0));
    vecs.push_back(mk(1,1,'h00,1,1,0, 0,0,1,'h06,4,0,0));
    vecs.push_back(mk(1,1,'h00,1,1,0, 0,0,1,'h06,3,0,0));
    vecs.push_back(mk(1,1,'h00,1,1,0, 0,0,1,'h06,2,0,0));
    vecs.push_back(mk(1,1,'h00,1,1,0, 0,0,1,'h06,1,0,0));
    // rsp coinciding with read pop, then a true underflow
    vecs.push_back(mk(1,0,'h07,1,1,0, 1,0,1,'h06,0,0,0));
    vecs.push_back(mk(1,1,'h00,0,0,0, 0,1,0,'h07,0,0,0));
    vecs.push_back(mk(1,1,'h00,1,0,0, 0,1,0,'h07,0,0,0));
    vecs.push_back(mk(1,1,'h00,1,1,0, 0,0,0,'h07,0,0,0));
    vecs.push_back(mk(1,1,'h00,1,0,0, 0,0,0,'h07,0,0,1));
    // flush with two reads in flight
    vecs.push_back(mk(1,0,'h08,1,0,0, 1,0,0,'h07,0,0,1));
    vecs.push_back(mk(1,0,'h09,1,0,0, 1,1,0,'h08,1,0,1));
    vecs.push_back(mk(1,1,'h00,1,0,0, 0,1,0,'h09,2,0,1));
    vecs.push_back(mk(1,1,'h00,1,0,1, 0,0,0,'h09,2,0,1));
    vecs.push_back(mk(1,0,'h0A,1,0,0, 0,0,0,'h09,2,0,1));
    vecs.push_back(mk(1,0,'h0A,1,1,0, 0,0,0,'h09,2,0,1));
    vecs.push_back(mk(1,0,'h0A,1,0,1, 0,0,0,'h09,1,0,1));
    vecs.push_back(mk(1,0,'h0A,1,1,0, 0,0,0,'h09,1,0,1));
    vecs.push_back(mk(1,0,'h0A,1,0,0, 0,0,0,'h09,0,1,1));
    vecs.push_back(mk(1,0,'h0A,1,0,0, 1,0,0,'h09,0,0,1));
    vecs.push_back(mk(1,1,'h00,0,0,0, 0,1,0,'h0A,1,0,1));
    // reset while holding with three reads outstanding
    vecs.push_back(mk(1,0,'h0B,1,0,0, 1,1,0,'h0A,1,0,1));
    vecs.push_back(mk(1,0,'h0C,1,0,0, 1,1,0,'h0B,2,0,1));
    vecs.push_back(mk(1,0,'h0D,0,0,0, 0,1,0,'h0C,3,0,1));
    vecs.push_back(mk(0,0,'h0D,0,0,0, 0,0,0,'h00,0,0,0));
    vecs.push_back(mk(1,0,'h0D,1,0,0, 1,0,0,'h00,0,0,0));
    vecs.push_back(mk(1,1,'h00,1,0,0, 0,1,0,'h0D,1,0,0));

    reset_n = 1'b0; fifo_empty = 1'b1; fifo_read_data = '0;
    cmd_ready = 1'b0; rsp_valid = 1'b0; flush = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      reset_n        = vecs[i].rst_n;
      fifo_empty     = vecs[i].empty;
      fifo_read_data = vecs[i].data;
      cmd_ready      = vecs[i].rdy;
      rsp_valid      = vecs[i].rsp;
      flush          = vecs[i].fl;
      #1;
      check($sformatf("vec%0d", i), actual(), vecs[i].exp);
      @(negedge clk);
    end

    // flush draining the last outstanding read, bounded wait for the pulse
    fifo_empty = 1'b1; cmd_ready = 1'b1; flush = 1'b1; rsp_valid = 1'b0;
    @(negedge clk);
    flush = 1'b0; rsp_valid = 1'b1;
    @(negedge clk);
    rsp_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      #1;
      if (flush_done) seen = 1'b1;
      else @(negedge clk);
    end
    check("flush_done_seen", {15'd0, seen}, 16'd1);
    @(negedge clk);
    #1;
    check("flush_done_one_cycle", {11'd0, flush_done, outstanding}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
